// File: rtl/alu2_pkg.sv
// Shared opcode encodings, widths and flag bit positions for the alu2 slice.
package alu2_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned SHAMT_W = 6;
    localparam int unsigned FLAGS_W = 4;

    // Bit positions inside flags_q = {negative, zero, carry, overflow}
    localparam int unsigned FLAG_NEG   = 3;
    localparam int unsigned FLAG_ZERO  = 2;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 0;

    typedef enum logic [OP_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    // Opcodes that run the shared adder in subtract mode
    function automatic logic uses_sub(input logic [OP_W-1:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu2_if.sv
// Operand/result bundle between the issuing logic (master) and the ALU (slave).
interface alu2_if
    import alu2_pkg::*;
#(
    parameter int unsigned WIDTH = 64
);
    logic        [WIDTH-1:0]   rs1;
    logic        [WIDTH-1:0]   rs2;
    logic        [OP_W-1:0]    ALUControl;
    logic signed [WIDTH-1:0]   rd;
    logic                      zero;
    logic        [FLAGS_W-1:0] flags_q;

    modport master (
        output rs1, rs2, ALUControl,
        input  rd, zero, flags_q
    );

    modport slave (
        input  rs1, rs2, ALUControl,
        output rd, zero, flags_q
    );
endinterface

// File: rtl/alu2_addsub.sv
// WIDTH-bit adder/subtractor shared by ADD, SUB, SLT and SLTU.
module alu2_addsub #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);
    localparam int unsigned EXT_W = WIDTH + 1;

    logic [WIDTH-1:0] w_b;
    logic [EXT_W-1:0] w_ext;

    // Subtract as a + ~b + 1, so carry-out doubles as "no borrow"
    assign w_b   = i_sub ? ~i_b : i_b;
    assign w_ext = {1'b0, i_a} + {1'b0, w_b} + EXT_W'(i_sub);

    assign o_sum      = w_ext[WIDTH-1:0];
    assign o_carry    = w_ext[WIDTH];
    assign o_overflow = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/alu2.sv
// Combinational ALU with a registered copy of the previous operation's flags.
module alu2
    import alu2_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic  clk,
    input  logic  reset,
    alu2_if.slave bus
);
    logic [WIDTH-1:0]   w_sum;
    logic               w_as_carry;
    logic               w_as_ovf;
    logic               w_sub;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lt_s;
    logic               w_lt_u;
    logic [WIDTH-1:0]   w_rd;
    logic               w_carry;
    logic               w_ovf;
    logic [FLAGS_W-1:0] w_flags;
    logic [FLAGS_W-1:0] r_flags;

    assign w_sub   = uses_sub(bus.ALUControl);
    assign w_shamt = bus.rs2[SHAMT_W-1:0];

    alu2_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a        (bus.rs1),
        .i_b        (bus.rs2),
        .i_sub      (w_sub),
        .o_sum      (w_sum),
        .o_carry    (w_as_carry),
        .o_overflow (w_as_ovf)
    );

    // Comparisons derived from rs1 - rs2
    assign w_lt_s = w_sum[WIDTH-1] ^ w_as_ovf;
    assign w_lt_u = ~w_as_carry;

    // Result multiplexer; undefined opcodes fall through to zero
    always_comb begin
        w_rd    = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.ALUControl)
            ALU_AND:  w_rd = bus.rs1 & bus.rs2;
            ALU_OR:   w_rd = bus.rs1 | bus.rs2;
            ALU_XOR:  w_rd = bus.rs1 ^ bus.rs2;
            ALU_ADD, ALU_SUB: begin
                w_rd    = w_sum;
                w_carry = w_as_carry;
                w_ovf   = w_as_ovf;
            end
            ALU_SLL:  w_rd = bus.rs1 << w_shamt;
            ALU_SRL:  w_rd = bus.rs1 >> w_shamt;
            ALU_SRA:  w_rd = $signed(bus.rs1) >>> w_shamt;
            ALU_SLT:  w_rd = WIDTH'(w_lt_s);
            ALU_SLTU: w_rd = WIDTH'(w_lt_u);
            default:  w_rd = '0;
        endcase
    end

    always_comb begin
        w_flags             = '0;
        w_flags[FLAG_NEG]   = w_rd[WIDTH-1];
        w_flags[FLAG_ZERO]  = (w_rd == '0);
        w_flags[FLAG_CARRY] = w_carry;
        w_flags[FLAG_OVF]   = w_ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags;
        end
    end

    assign bus.rd      = w_rd;
    assign bus.zero    = w_flags[FLAG_ZERO];
    assign bus.flags_q = r_flags;
endmodule

// File: tb/tb_alu2.sv
// Directed + random scoreboard bench for alu2: combinational result and registered flags.
module tb_alu2;
    import alu2_pkg::*;

    localparam int unsigned W = 64;

    typedef struct {
        string      tag;
        logic [W-1:0] rd;
        logic       zero;
    } comb_exp_t;

    typedef struct {
        string      tag;
        logic [3:0] flags;
    } flag_exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    comb_exp_t sb_comb[$];
    flag_exp_t sb_flags[$];

    alu2_if #(.WIDTH(W)) bus ();

    alu2 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: wide signed arithmetic for overflow, direct compares for carry
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [3:0] f);
        logic [W:0] s;
        logic       c;
        logic       v;
        int         sh;
        sh = int'(b[5:0]);
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0010: begin
                r = a + b;
                c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
                s = {a[W-1], a} + {b[W-1], b};
                v = s[W] != s[W-1];
            end
            4'b0110: begin
                r = a - b;
                c = (a >= b);
                s = {a[W-1], a} - {b[W-1], b};
                v = s[W] != s[W-1];
            end
            4'b0100: r = a << sh;
            4'b0101: r = a >> sh;
            4'b1000: r = $signed(a) >>> sh;
            4'b0111: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1001: r = (a < b) ? 64'd1 : 64'd0;
            default: r = '0;
        endcase
        f = {r[W-1], (r == '0), c, v};
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation, check the combinational result, then the flags after the edge
    task automatic step(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [3:0]   f;
        comb_exp_t    ce;
        flag_exp_t    fe;
        bus.ALUControl = op;
        bus.rs1        = a;
        bus.rs2        = b;
        model(op, a, b, r, f);
        sb_comb.push_back('{tag, r, (r == '0)});
        sb_flags.push_back('{tag, reset ? 4'b0000 : f});
        #1;
        if (sb_comb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            ce = sb_comb.pop_front();
            chk({ce.tag, "_rd"}, bus.rd, ce.rd);
            chk({ce.tag, "_zero"}, W'(bus.zero), W'(ce.zero));
        end
        @(posedge clk);
        #1;
        if (sb_flags.size() == 0) begin
            chk({tag, "_sbf_empty"}, 64'd0, 64'd1);
        end else begin
            fe = sb_flags.pop_front();
            chk({fe.tag, "_flags_q"}, W'(bus.flags_q), W'(fe.flags));
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.ALUControl = 4'b0000;

        #3;
        chk("reset_flags", W'(bus.flags_q), 64'd0);
        @(posedge clk);
        #1;
        chk("reset_hold_flags", W'(bus.flags_q), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        step("add", 4'b0010, 64'h0000_0000_0000_1000, 64'd4);
        chk("add_const", bus.rd, 64'h1004);
        chk("add_flags_const", W'(bus.flags_q), 64'h0);

        step("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add_wrap_flags_const", W'(bus.flags_q), 64'h6);

        step("sub_ovf", 4'b0110, 64'h8000_0000_0000_0000, 64'd1);
        chk("sub_ovf_const", bus.rd, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_ovf_flags_const", W'(bus.flags_q), 64'h3);

        step("sub_borrow", 4'b0110, 64'd3, 64'd5);
        step("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);

        step("slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("slt_const", bus.rd, 64'd1);
        step("sltu", 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("sltu_const", bus.rd, 64'd0);
        step("slt_ovf_case", 4'b0111, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);

        step("srl", 4'b0101, 64'h8000_0000_0000_0000, 64'h43);
        chk("srl_const", bus.rd, 64'h1000_0000_0000_0000);
        step("sra", 4'b1000, 64'h8000_0000_0000_0000, 64'h43);
        chk("sra_const", bus.rd, 64'hF000_0000_0000_0000);
        step("sll63", 4'b0100, 64'd1, 64'd63);
        chk("sll63_const", bus.rd, 64'h8000_0000_0000_0000);
        step("sll0", 4'b0100, 64'hDEAD_BEEF_0123_4567, 64'hFFC0);
        chk("sll0_const", bus.rd, 64'hDEAD_BEEF_0123_4567);

        step("and", 4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        step("or",  4'b0001, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0000_0000_0001);
        step("xor", 4'b0011, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA);

        // Latch nonzero flags, then reset mid-cycle
        step("pre_reset", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_flags", W'(bus.flags_q), 64'd0);
        step("in_reset_add", 4'b0010, 64'd5, 64'd7);
        chk("in_reset_rd_const", bus.rd, 64'd12);
        step("undef_1111", 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("undef_rd_const", bus.rd, 64'd0);
        chk("undef_zero_const", W'(bus.zero), 64'd1);
        #2;
        reset = 1'b0;
        step("post_reset", 4'b0110, 64'd1, 64'd2);
        chk("post_reset_flags_const", W'(bus.flags_q), 64'h8);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [3:0]   op;
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            op = 4'($urandom_range(0, 15));
            if (i % 5 == 0) b = a;
            if (i % 7 == 0) a = {1'b1, 63'd0};
            step("rand", op, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu2.md
ALU2 -- requirements
Module: alu2

Interface
REQ-001 Parameter: WIDTH, default 64, datapath width in bits.
REQ-002 clk  input  1  clock; status register samples on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset of the status register.
REQ-004 rs1  input  WIDTH  operand A.
REQ-005 rs2  input  WIDTH  operand B; shift amount is rs2[5:0].
REQ-006 ALUControl  input  4  operation select.
REQ-007 rd  output  WIDTH (signed)  result, combinational.
REQ-008 zero  output  1  combinational; high when rd == 0.
REQ-009 flags_q  output  4  registered {negative, zero, carry, overflow} of the previous cycle's operation.

Function
REQ-010 rd SHALL be purely combinational from rs1, rs2 and ALUControl, with zero-cycle latency; clk and reset SHALL NOT affect rd.
REQ-011 The encodings SHALL be: 0000 AND; 0001 OR; 0010 ADD (rs1+rs2); 0011 XOR; 0100 SLL; 0101 SRL; 0110 SUB (rs1-rs2); 0111 SLT (signed, result 1/0); 1000 SRA; 1001 SLTU (unsigned, result 1/0).
REQ-012 Encodings 1010-1111 SHALL yield rd = 0, with carry = 0 and overflow = 0.
REQ-013 ADD and SUB SHALL wrap modulo 2^WIDTH; carry = carry-out for ADD and NOT borrow for SUB (rs1 >= rs2 unsigned).
REQ-014 Overflow SHALL be set for ADD when the operands have equal signs and the result sign differs, and for SUB when the operands have different signs and the result sign differs from rs1; it SHALL be 0 for all other operations.
REQ-015 Shifts SHALL use only rs2[5:0] (0..63); a shift by 0 SHALL return rs1 unchanged; SRA SHALL replicate rs1[63].
REQ-016 SLT SHALL compare two's-complement values; SLTU SHALL compare unsigned values; the upper WIDTH-1 bits of rd SHALL be zero.
REQ-017 negative SHALL equal rd[WIDTH-1]; zero SHALL equal (rd == 0).
REQ-018 On each rising clk edge with reset low, flags_q SHALL load {negative, zero, carry, overflow} of the current operation.
REQ-019 The block SHALL contain no other state; every output SHALL be defined for all input combinations (no X propagation from the select).

Reset
REQ-020 Asserting reset SHALL immediately clear flags_q to 4'b0000, independent of clk.
REQ-021 reset SHALL have no effect on rd or zero; rd SHALL remain valid throughout reset.
REQ-022 After reset deasserts, flags_q SHALL update on the first subsequent rising clk edge.

Structure
REQ-023 The opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SRA, ALU_SLTU) and the flag bit indices SHALL reside in the shared package alu2_pkg.
REQ-024 A single sub-module, alu2_addsub (WIDTH-bit adder/subtractor producing sum, carry and overflow), SHALL be shared by ADD, SUB, SLT and SLTU.
REQ-025 The result multiplexer and the flag register SHALL reside in alu2.

Verification
REQ-026 ADD: rs1=0x0000_0000_0000_1000, rs2=4, ALUControl=0010 -> rd=0x1004 in the same cycle, carry=0, overflow=0.
REQ-027 ADD wrap: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> rd=0, zero=1, carry=1, overflow=0; after the next clk edge flags_q=4'b0110.
REQ-028 SUB overflow: rs1=0x8000_0000_0000_0000, rs2=1, ALUControl=0110 -> rd=0x7FFF_FFFF_FFFF_FFFF, overflow=1, carry=1.
REQ-029 SLT vs SLTU: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> SLT rd=1; SLTU rd=0.
REQ-030 Shifts: rs1=0x8000_0000_0000_0000, rs2=0x43 (uses 3) -> SRL rd=0x1000_0000_0000_0000; SRA rd=0xF000_0000_0000_0000; SLL of rs1=1 by 63 -> rd=0x8000_0000_0000_0000.
REQ-031 Reset and undefined opcode: with flags_q nonzero, assert reset mid-cycle -> flags_q=0 immediately while rd keeps tracking its inputs; ALUControl=1111 -> rd=0, zero=1.
